qos_vc_buffer: RTL

// - Parametrised VC buffering stage for the PCIe QoS datapath: NUM_VC classes, configurable depth and width.
// - Each input word is routed by its VC-id field into a per-VC FIFO.
// - Words drain through one registered output port under VC arbitration.
// - Embeds the init/idle/active/error condition FSM with per-VC HIGH/LOW thresholds.
// - Sits between the main FIFO and the destination demux.
//

---
 rtl/qos_vc_buffer_if.sv | 21 ++
 rtl/qos_vc_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/qos_vc_buffer_if.sv
// rtl/qos_vc_buffer_if.sv - write/drain handshake bundle for the QoS VC buffer
interface qos_vc_buffer_if #(
    parameter int BW = 6
);
    logic          in_wr;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          pause;

    modport master (
        output in_wr, in_data, out_ready,
        input  out_valid, out_data, pause
    );

    modport slave (
        input  in_wr, in_data, out_ready,
        output out_valid, out_data, pause
    );
endinterface

// File: rtl/qos_vc_buffer.sv
// rtl/qos_vc_buffer.sv - per-VC FIFO buffering stage with threshold flags and condition FSM
// QOS_RR_ARB_EN selects round-robin arbitration; default is strict priority (VC0 highest).
module qos_vc_buffer #(
    parameter  int BW     = 6,
    parameter  int NUM_VC = 2,
    parameter  int DEPTH  = 16,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int VCW    = $clog2(NUM_VC)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [NUM_VC*CW-1:0] umbral_high_cfg,
    input  logic [NUM_VC*CW-1:0] umbral_low_cfg,
    qos_vc_buffer_if.slave       bus,
    output logic [NUM_VC-1:0]    vc_empty,
    output logic [NUM_VC-1:0]    vc_almost_full,
    output logic [NUM_VC-1:0]    vc_almost_empty,
    output logic [NUM_VC-1:0]    error_full,
    output logic                 idle_out,
    output logic                 active_out,
    output logic                 error_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;
    state_t state, state_nxt;

    logic [BW-1:0]  mem      [NUM_VC][DEPTH];
    logic [AW-1:0]  wr_ptr   [NUM_VC];
    logic [AW-1:0]  rd_ptr   [NUM_VC];
    logic [CW-1:0]  count    [NUM_VC];
    logic [CW-1:0]  high_thr [NUM_VC];
    logic [CW-1:0]  low_thr  [NUM_VC];

    logic [NUM_VC-1:0] nonempty, full, pop, push_sel;
    logic [VCW-1:0]    push_vc, grant;
    logic              push_en, load, overflow, accept, any_nonempty;
    logic              out_valid_q;
    logic [BW-1:0]     out_data_q, head;

    assign push_vc      = bus.in_data[BW-1 -: VCW];
    assign push_en      = bus.in_wr && (state != ST_INIT);
    assign any_nonempty = |nonempty;
    assign load         = (!out_valid_q || bus.out_ready) && any_nonempty && (state != ST_INIT);
    // A full VC still takes a word if the same cycle pops it, so only pop-less pushes overflow.
    assign overflow     = push_en && full[push_vc] && !pop[push_vc];
    assign accept       = push_en && !overflow;
    assign head         = mem[grant][rd_ptr[grant]];

    always_comb begin
        nonempty        = '0;
        full            = '0;
        pop             = '0;
        push_sel        = '0;
        vc_empty        = '0;
        vc_almost_full  = '0;
        vc_almost_empty = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            nonempty[v]        = (count[v] != '0);
            full[v]            = (count[v] == CW'(DEPTH));
            pop[v]             = load && (grant == VCW'(v));
            push_sel[v]        = accept && (push_vc == VCW'(v));
            vc_empty[v]        = (count[v] == '0);
            vc_almost_full[v]  = (count[v] >= high_thr[v]);
            vc_almost_empty[v] = (count[v] <= low_thr[v]);
        end
    end

    assign bus.pause = |vc_almost_full;

`ifdef QOS_RR_ARB_EN
    logic [VCW-1:0] rr_ptr;

    always_comb begin
        logic           found;
        logic [VCW-1:0] idx;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = rr_ptr + VCW'(i);
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            rr_ptr <= '0;
        else if (load)
            rr_ptr <= grant + VCW'(1);
    end
`else
    always_comb begin
        grant = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (nonempty[i])
                grant = VCW'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (accept)
            mem[push_vc][wr_ptr[push_vc]] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int v = 0; v < NUM_VC; v++) begin
                count[v]  <= '0;
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_sel[v] && !pop[v])
                    count[v] <= count[v] + CW'(1);
                else if (!push_sel[v] && pop[v])
                    count[v] <= count[v] - CW'(1);
                if (push_sel[v])
                    wr_ptr[v] <= wr_ptr[v] + AW'(1);
                if (pop[v])
                    rd_ptr[v] <= rd_ptr[v] + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int v = 0; v < NUM_VC; v++) begin
                high_thr[v] <= CW'(DEPTH - 1);
                low_thr[v]  <= CW'(1);
            end
        end else if (state == ST_INIT) begin
            for (int v = 0; v < NUM_VC; v++) begin
                high_thr[v] <= umbral_high_cfg[v*CW +: CW];
                low_thr[v]  <= umbral_low_cfg[v*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= head;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            error_full <= '0;
        else if (state_nxt == ST_INIT)
            error_full <= '0;
        else if (overflow)
            error_full[push_vc] <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            state <= ST_RESET;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   if (!init) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (overflow)
                    state_nxt = ST_ERROR;
                else if (any_nonempty || out_valid_q)
                    state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (overflow)
                    state_nxt = ST_ERROR;
                else if (!any_nonempty && !out_valid_q)
                    state_nxt = ST_IDLE;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase
        if (init && state != ST_RESET)
            state_nxt = ST_INIT;
    end

    assign idle_out   = (state == ST_IDLE);
    assign active_out = (state == ST_ACTIVE);
    assign error_out  = (state == ST_ERROR);
endmodule
